alu_unit: RTL and testbench

- Execution unit on the far side of the reservation-station dispatch interface.
- Accepts one ready instruction per cycle (start_alu plus operands) and computes the RV32I integer, branch or jump result.
- Queues the results in a small result FIFO and presents them on the ALU broadcast port: alu_ready, finished_alu_rob_entry, alu_result, next_pc.
- Head entry is popped when the common-data-bus arbiter grants it; rob_clear_up flushes all in-flight work.

---
 rtl/alu_unit.sv | 269 ++++++++++++++++++++++++++
 tb/tb_alu_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_unit.sv
// -----------------------------------------------------------------------------
// alu_unit
//
// RV32I integer/branch/jump execution unit that sits behind the reservation
// station dispatch port. One ready instruction per cycle is evaluated
// combinationally. The result is written into a small result FIFO on the
// same clock edge. The FIFO head is presented on the ALU broadcast port until
// the common-data-bus arbiter grants it.
//
// Ports
//   clk_in                  system clock, all state on rising edge
//   rst_in                  asynchronous active-low reset
//   rdy_in                  global ready; low freezes all state
//   rob_clear_up            mispredict flush, empties the FIFO
//   start_alu               dispatch valid from the reservation station
//   vi / vj                 rs1 / rs2 operand values
//   imm                     sign-extended immediate
//   inst_addr               instruction PC
//   op / op_type            funct3 / opcode
//   op_addition             inst[30], SUB/SRA select
//   alu_rob_entry           destination ROB tag
//   alu_full                FIFO full; dispatch must not be attempted
//   cdb_grant               arbiter grants the broadcast this cycle
//   alu_ready               FIFO head valid
//   finished_alu_rob_entry  head ROB tag
//   alu_result              head result value
//   next_pc                 head resolved next PC
// -----------------------------------------------------------------------------
module alu_unit #(
  parameter int ROB_BIT    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               rob_clear_up,
  input  logic               start_alu,
  input  logic [31:0]        vi,
  input  logic [31:0]        vj,
  input  logic [31:0]        imm,
  input  logic [31:0]        inst_addr,
  input  logic [2:0]         op,
  input  logic [6:0]         op_type,
  input  logic               op_addition,
  input  logic [ROB_BIT-1:0] alu_rob_entry,
  output logic               alu_full,
  input  logic               cdb_grant,
  output logic               alu_ready,
  output logic [ROB_BIT-1:0] finished_alu_rob_entry,
  output logic [31:0]        alu_result,
  output logic [31:0]        next_pc
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // ---------------------------------------------------------------------------
  // Arithmetic helpers
  // ---------------------------------------------------------------------------

  // Integer operation selected by funct3. alt selects SUB for funct3=000 and
  // SRA for funct3=101; the caller decides whether alt is meaningful.
  function automatic logic [31:0] int_op(input logic [2:0]  f3,
                                         input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic        alt);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic        [4:0]  shamt;
    logic        [31:0] r;
    sa    = a;
    sb    = b;
    shamt = b[4:0];
    r     = '0;
    case (f3)
      3'b000:  r = alt ? (a - b) : (a + b);
      3'b001:  r = a << shamt;
      3'b010:  r = (sa < sb) ? 32'd1 : 32'd0;
      3'b011:  r = (a < b) ? 32'd1 : 32'd0;
      3'b100:  r = a ^ b;
      3'b101:  r = alt ? 32'(sa >>> shamt) : (a >> shamt);
      3'b110:  r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  // Branch condition evaluation; unused funct3 encodings are never taken.
  function automatic logic branch_taken(input logic [2:0]  f3,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic               t;
    sa = a;
    sb = b;
    case (f3)
      3'b000:  t = (a == b);
      3'b001:  t = (a != b);
      3'b100:  t = (sa < sb);
      3'b101:  t = (sa >= sb);
      3'b110:  t = (a < b);
      3'b111:  t = (a >= b);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  // ---------------------------------------------------------------------------
  // Combinational execute
  // ---------------------------------------------------------------------------
  logic [31:0] exe_result;
  logic [31:0] exe_next_pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_plus_imm;
  logic [31:0] jalr_target;

  assign pc_plus4    = inst_addr + 32'd4;
  assign pc_plus_imm = inst_addr + imm;
  // JALR clears bit 0 of the computed target.
  assign jalr_target = (vi + imm) & 32'hFFFF_FFFE;

  always_comb begin
    exe_result  = '0;
    exe_next_pc = pc_plus4;
    case (op_type)
      OPC_R: begin
        exe_result = int_op(op, vi, vj, op_addition);
      end
      OPC_I: begin
        // Only the right shift honours inst[30]; ADDI never subtracts.
        exe_result = int_op(op, vi, imm, op_addition && (op == 3'b101));
      end
      OPC_LUI: begin
        exe_result = imm;
      end
      OPC_AUIPC: begin
        exe_result = pc_plus_imm;
      end
      OPC_JAL: begin
        exe_result  = pc_plus4;
        exe_next_pc = pc_plus_imm;
      end
      OPC_JALR: begin
        exe_result  = pc_plus4;
        exe_next_pc = jalr_target;
      end
      OPC_BRANCH: begin
        if (branch_taken(op, vi, vj)) begin
          exe_result  = 32'd1;
          exe_next_pc = pc_plus_imm;
        end else begin
          exe_result  = 32'd0;
          exe_next_pc = pc_plus4;
        end
      end
      default: begin
        exe_result  = '0;
        exe_next_pc = pc_plus4;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Result FIFO
  // ---------------------------------------------------------------------------
  logic [ROB_BIT-1:0] tag_mem [FIFO_DEPTH];
  logic [31:0]        res_mem [FIFO_DEPTH];
  logic [31:0]        npc_mem [FIFO_DEPTH];

  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Copy of the most recently presented head, shown while the FIFO is empty.
  logic [ROB_BIT-1:0] last_tag_q, last_tag_d;
  logic [31:0]        last_res_q, last_res_d;
  logic [31:0]        last_npc_q, last_npc_d;

  logic               not_empty;
  logic               push;
  logic               pop;

  assign not_empty = (count_q != '0);
  // Full is decoded from the registered count only, so it has no path from
  // cdb_grant.
  assign alu_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign push      = start_alu && !alu_full;
  assign pop       = not_empty && cdb_grant;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    last_tag_d = last_tag_q;
    last_res_d = last_res_q;
    last_npc_d = last_npc_q;
    if (rdy_in) begin
      if (not_empty) begin
        last_tag_d = tag_mem[head_q];
        last_res_d = res_mem[head_q];
        last_npc_d = npc_mem[head_q];
      end
      if (rob_clear_up) begin
        // Flush drops every queued entry and any concurrent dispatch.
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (push) begin
          tail_d = tail_q + PTR_W'(1);
        end
        if (pop) begin
          head_d = head_q + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   count_d = count_q + CNT_W'(1);
          2'b01:   count_d = count_q - CNT_W'(1);
          default: count_d = count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      last_tag_q <= '0;
      last_res_q <= '0;
      last_npc_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      last_tag_q <= last_tag_d;
      last_res_q <= last_res_d;
      last_npc_q <= last_npc_d;
    end
  end

  // Storage carries no reset: an entry is only observed once count says it
  // was written.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !rob_clear_up && push) begin
      tag_mem[tail_q] <= alu_rob_entry;
      res_mem[tail_q] <= exe_result;
      npc_mem[tail_q] <= exe_next_pc;
    end
  end

  // ---------------------------------------------------------------------------
  // Broadcast port
  // ---------------------------------------------------------------------------
  assign alu_ready              = not_empty;
  assign finished_alu_rob_entry = not_empty ? tag_mem[head_q] : last_tag_q;
  assign alu_result             = not_empty ? res_mem[head_q] : last_res_q;
  assign next_pc                = not_empty ? npc_mem[head_q] : last_npc_q;

endmodule

// File: tb/tb_alu_unit.sv
module tb_alu_unit;

  localparam logic [6:0] OR_T  = 7'b0110011;
  localparam logic [6:0] OI_T  = 7'b0010011;
  localparam logic [6:0] OLUI  = 7'b0110111;
  localparam logic [6:0] OAUI  = 7'b0010111;
  localparam logic [6:0] OJAL  = 7'b1101111;
  localparam logic [6:0] OJALR = 7'b1100111;
  localparam logic [6:0] OBR   = 7'b1100011;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        rob_clear_up;
  logic        start_alu;
  logic [31:0] vi, vj, imm, inst_addr;
  logic [2:0]  op;
  logic [6:0]  op_type;
  logic        op_addition;
  logic [3:0]  alu_rob_entry;
  logic        alu_full;
  logic        cdb_grant;
  logic        alu_ready;
  logic [3:0]  finished_alu_rob_entry;
  logic [31:0] alu_result;
  logic [31:0] next_pc;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [6:0]  ot;
    logic [2:0]  f3;
    logic        add;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] im;
    logic [31:0] pc;
    logic [31:0] res;
    logic [31:0] npc;
  } vec_t;

  vec_t vecs [19];

  alu_unit #(.ROB_BIT(4), .FIFO_DEPTH(4)) dut (
    .clk_in                 (clk_in),
    .rst_in                 (rst_in),
    .rdy_in                 (rdy_in),
    .rob_clear_up           (rob_clear_up),
    .start_alu              (start_alu),
    .vi                     (vi),
    .vj                     (vj),
    .imm                    (imm),
    .inst_addr              (inst_addr),
    .op                     (op),
    .op_type                (op_type),
    .op_addition            (op_addition),
    .alu_rob_entry          (alu_rob_entry),
    .alu_full               (alu_full),
    .cdb_grant              (cdb_grant),
    .alu_ready              (alu_ready),
    .finished_alu_rob_entry (finished_alu_rob_entry),
    .alu_result             (alu_result),
    .next_pc                (next_pc)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Drive an ADD instruction whose result is 100+tag, so order is visible.
  task automatic drive_add(input logic [3:0] tag);
    start_alu     = 1'b1;
    op_type       = OR_T;
    op            = 3'b000;
    op_addition   = 1'b0;
    vi            = 32'd100;
    vj            = {28'd0, tag};
    imm           = 32'd0;
    inst_addr     = 32'h200;
    alu_rob_entry = tag;
  endtask

  task automatic test_reset();
    rst_in = 1'b0; rdy_in = 1'b1; rob_clear_up = 1'b0; start_alu = 1'b0;
    cdb_grant = 1'b0; vi = '0; vj = '0; imm = '0; inst_addr = '0;
    op = '0; op_type = '0; op_addition = 1'b0; alu_rob_entry = '0;
    tick(); tick();
    n_checks++; if (alu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", alu_ready); end
    n_checks++; if (alu_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", alu_full); end
    n_checks++; if ({finished_alu_rob_entry, alu_result, next_pc} !== 68'd0) begin n_fail++; $display("FAIL reset_outputs got tag=%h res=%h npc=%h want 0", finished_alu_rob_entry, alu_result, next_pc); end
    rst_in = 1'b1;
    tick();
  endtask

  task automatic test_ops(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      start_alu = 1'b1; cdb_grant = 1'b1;
      op_type = vecs[i].ot; op = vecs[i].f3; op_addition = vecs[i].add;
      vi = vecs[i].a; vj = vecs[i].b; imm = vecs[i].im; inst_addr = vecs[i].pc;
      alu_rob_entry = 4'(i);
      tick();
      start_alu = 1'b0;
      n_checks++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL vec%0d_ready got %b want 1", i, alu_ready); end
      n_checks++; if (finished_alu_rob_entry !== 4'(i)) begin n_fail++; $display("FAIL vec%0d_tag got %0d want %0d", i, finished_alu_rob_entry, i); end
      n_checks++; if (alu_result !== vecs[i].res) begin n_fail++; $display("FAIL vec%0d_result got %h want %h", i, alu_result, vecs[i].res); end
      n_checks++; if (next_pc !== vecs[i].npc) begin n_fail++; $display("FAIL vec%0d_next_pc got %h want %h", i, next_pc, vecs[i].npc); end
      tick();
      n_checks++; if (alu_ready !== 1'b0) begin n_fail++; $display("FAIL vec%0d_popped got %b want 0", i, alu_ready); end
      n_checks++; if (alu_result !== vecs[i].res) begin n_fail++; $display("FAIL vec%0d_hold got %h want %h", i, alu_result, vecs[i].res); end
    end
    cdb_grant = 1'b0;
  endtask

  task automatic test_backpressure();
    cdb_grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (alu_full !== 1'b0) begin n_fail++; $display("FAIL bp_not_full_%0d got %b want 0", i, alu_full); end
      drive_add(4'(i));
      tick();
    end
    n_checks++; if (alu_full !== 1'b1) begin n_fail++; $display("FAIL bp_full got %b want 1", alu_full); end
    drive_add(4'd9);  // dropped: FIFO full
    tick();
    start_alu = 1'b0;
    n_checks++; if (alu_full !== 1'b1) begin n_fail++; $display("FAIL bp_still_full got %b want 1", alu_full); end
    cdb_grant = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (finished_alu_rob_entry !== 4'(i) || alu_ready !== 1'b1) begin n_fail++; $display("FAIL bp_order_%0d got tag=%0d rdy=%b want tag=%0d rdy=1", i, finished_alu_rob_entry, alu_ready, i); end
      n_checks++; if (alu_result !== 32'(100 + i)) begin n_fail++; $display("FAIL bp_result_%0d got %0d want %0d", i, alu_result, 100 + i); end
      tick();
      n_checks++; if (alu_full !== 1'b0) begin n_fail++; $display("FAIL bp_full_fall_%0d got %b want 0", i, alu_full); end
    end
    n_checks++; if (alu_ready !== 1'b0) begin n_fail++; $display("FAIL bp_drained got %b want 0", alu_ready); end
    cdb_grant = 1'b0;
  endtask

  task automatic test_back_to_back();
    // Start while full with a concurrent grant: the start is dropped.
    for (int i = 0; i < 4; i++) begin drive_add(4'(i + 1)); tick(); end
    drive_add(4'd12); cdb_grant = 1'b1;
    tick();
    start_alu = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      n_checks++; if (finished_alu_rob_entry !== 4'(i) || alu_ready !== 1'b1) begin n_fail++; $display("FAIL full_push_order got tag=%0d rdy=%b want tag=%0d", finished_alu_rob_entry, alu_ready, i); end
      tick();
    end
    n_checks++; if (alu_ready !== 1'b0) begin n_fail++; $display("FAIL full_push_dropped got rdy=%b tag=%0d want rdy=0", alu_ready, finished_alu_rob_entry); end
    // Push and pop together at count=3, across pointer wrap.
    cdb_grant = 1'b0;
    for (int i = 4; i < 7; i++) begin drive_add(4'(i)); tick(); end
    cdb_grant = 1'b1;
    for (int i = 7; i < 11; i++) begin
      drive_add(4'(i));
      n_checks++; if (finished_alu_rob_entry !== 4'(i - 3)) begin n_fail++; $display("FAIL bb_head_%0d got %0d want %0d", i, finished_alu_rob_entry, i - 3); end
      tick();
      n_checks++; if (alu_full !== 1'b0 || alu_ready !== 1'b1) begin n_fail++; $display("FAIL bb_count_%0d got full=%b rdy=%b want full=0 rdy=1", i, alu_full, alu_ready); end
    end
    start_alu = 1'b0;
    for (int i = 8; i < 11; i++) begin
      n_checks++; if (finished_alu_rob_entry !== 4'(i) || alu_result !== 32'(100 + i)) begin n_fail++; $display("FAIL bb_drain_%0d got tag=%0d res=%0d", i, finished_alu_rob_entry, alu_result); end
      tick();
    end
    n_checks++; if (alu_ready !== 1'b0) begin n_fail++; $display("FAIL bb_empty got %b want 0", alu_ready); end
    cdb_grant = 1'b0;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin drive_add(4'(i)); tick(); end
    drive_add(4'd5); rob_clear_up = 1'b1;
    tick();
    rob_clear_up = 1'b0; start_alu = 1'b0;
    n_checks++; if (alu_ready !== 1'b0 || alu_full !== 1'b0) begin n_fail++; $display("FAIL flush_empty got rdy=%b full=%b want 0/0", alu_ready, alu_full); end
    // Count must restart from zero: full only after exactly four pushes.
    for (int i = 0; i < 3; i++) begin drive_add(4'(i + 6)); tick(); end
    n_checks++; if (alu_full !== 1'b0 || finished_alu_rob_entry !== 4'd6) begin n_fail++; $display("FAIL flush_count3 got full=%b tag=%0d want 0/6", alu_full, finished_alu_rob_entry); end
    drive_add(4'd9); tick(); start_alu = 1'b0;
    n_checks++; if (alu_full !== 1'b1) begin n_fail++; $display("FAIL flush_count4 got %b want 1", alu_full); end
    rob_clear_up = 1'b1; tick(); rob_clear_up = 1'b0;
  endtask

  task automatic test_freeze();
    drive_add(4'd1); tick();
    drive_add(4'd2); tick();
    rdy_in = 1'b0; cdb_grant = 1'b1; drive_add(4'd3);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (alu_ready !== 1'b1 || finished_alu_rob_entry !== 4'd1) begin n_fail++; $display("FAIL freeze_%0d got rdy=%b tag=%0d want 1/1", i, alu_ready, finished_alu_rob_entry); end
    end
    rdy_in = 1'b1; start_alu = 1'b0;
    tick();
    n_checks++; if (finished_alu_rob_entry !== 4'd2 || alu_ready !== 1'b1) begin n_fail++; $display("FAIL unfreeze_pop got tag=%0d rdy=%b want 2/1", finished_alu_rob_entry, alu_ready); end
    tick();
    n_checks++; if (alu_ready !== 1'b0) begin n_fail++; $display("FAIL freeze_no_push got rdy=%b tag=%0d want rdy=0", alu_ready, finished_alu_rob_entry); end
    cdb_grant = 1'b0;
  endtask

  task automatic test_async_reset();
    drive_add(4'd7); tick();
    drive_add(4'd8); tick();
    start_alu = 1'b0;
    #2 rst_in = 1'b0;
    #1;
    n_checks++; if (alu_ready !== 1'b0 || alu_full !== 1'b0) begin n_fail++; $display("FAIL areset_ctrl got rdy=%b full=%b want 0/0", alu_ready, alu_full); end
    n_checks++; if ({finished_alu_rob_entry, alu_result, next_pc} !== 68'd0) begin n_fail++; $display("FAIL areset_outputs got tag=%h res=%h npc=%h want 0", finished_alu_rob_entry, alu_result, next_pc); end
    tick();
    rst_in = 1'b1;
    tick();
    n_checks++; if (alu_ready !== 1'b0) begin n_fail++; $display("FAIL areset_empty got %b want 0", alu_ready); end
  endtask

  initial begin
    vecs[0]  = '{OR_T, 3'b000, 1'b0, 32'd5,         32'd7,  32'd0,         32'h40,  32'd12,        32'h44};
    vecs[1]  = '{OR_T, 3'b000, 1'b1, 32'h8000_0000, 32'd4,  32'd0,         32'h40,  32'h7FFF_FFFC, 32'h44};
    vecs[2]  = '{OR_T, 3'b101, 1'b1, 32'h8000_0000, 32'd4,  32'd0,         32'h40,  32'hF800_0000, 32'h44};
    vecs[3]  = '{OR_T, 3'b101, 1'b0, 32'h8000_0000, 32'd4,  32'd0,         32'h40,  32'h0800_0000, 32'h44};
    vecs[4]  = '{OI_T, 3'b000, 1'b1, 32'd1,         32'd9,  32'd2,         32'h40,  32'd3,         32'h44};
    vecs[5]  = '{OI_T, 3'b101, 1'b1, 32'h8000_0000, 32'd0,  32'h404,       32'h40,  32'hF800_0000, 32'h44};
    vecs[6]  = '{OR_T, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1,  32'd0,         32'h40,  32'd1,         32'h44};
    vecs[7]  = '{OR_T, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1,  32'd0,         32'h40,  32'd0,         32'h44};
    vecs[8]  = '{OR_T, 3'b001, 1'b0, 32'd1,         32'h23, 32'd0,         32'h40,  32'd8,         32'h44};
    vecs[9]  = '{OR_T, 3'b111, 1'b0, 32'hF0F0,      32'hFF00, 32'd0,       32'h40,  32'hF000,      32'h44};
    vecs[10] = '{OLUI, 3'b000, 1'b0, 32'd3,         32'd4,  32'h1234_5000, 32'h40,  32'h1234_5000, 32'h44};
    vecs[11] = '{OAUI, 3'b000, 1'b0, 32'd3,         32'd4,  32'h1000,      32'h100, 32'h1100,      32'h104};
    vecs[12] = '{7'b0000011, 3'b000, 1'b0, 32'd3,   32'd4,  32'h10,        32'h100, 32'd0,         32'h104};
    vecs[13] = '{OBR,  3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1,  32'h20,        32'h100, 32'd1,         32'h120};
    vecs[14] = '{OBR,  3'b110, 1'b0, 32'hFFFF_FFFF, 32'd1,  32'h20,        32'h100, 32'd0,         32'h104};
    vecs[15] = '{OJALR,3'b000, 1'b0, 32'h201,       32'd0,  32'h20,        32'h100, 32'h104,       32'h220};
    vecs[16] = '{OJAL, 3'b000, 1'b0, 32'd0,         32'd0,  32'h20,        32'h100, 32'h104,       32'h120};
    vecs[17] = '{OBR,  3'b000, 1'b0, 32'd5,         32'd5,  32'h20,        32'h100, 32'd1,         32'h120};
    vecs[18] = '{OBR,  3'b111, 1'b0, 32'd1,         32'hFFFF_FFFF, 32'h20, 32'h100, 32'd0,         32'h104};

    test_reset();
    test_ops(0, 12);
    test_ops(13, 18);
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_freeze();
    test_async_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
